// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: request/response memory port, prefetch queue of
// {pc, instr} entries, and branch/jump redirect with stale-response dropping.
module fetch_queue_stage #(
  parameter int unsigned WORD_LEN     = 16,
  parameter int unsigned ADDR_STEP    = 4,
  parameter int unsigned OFFSET_SHIFT = 1,
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned RESET_PC     = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                freeze_i,
  input  logic                br_taken_i,
  input  logic [WORD_LEN-1:0] br_pc_i,
  input  logic                jump_enable_i,
  input  logic [WORD_LEN-1:0] br_offset_i,
  output logic                imem_req_o,
  output logic [WORD_LEN-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rsp_valid_i,
  input  logic [WORD_LEN-1:0] imem_rsp_data_i,
  output logic                out_valid_o,
  output logic [WORD_LEN-1:0] pc_o,
  output logic [WORD_LEN-1:0] instruction_o
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned PW = $clog2(QDEPTH);

  typedef struct packed {
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] instr;
  } entry_t;

  entry_t              q_mem_q  [QDEPTH];
  logic [WORD_LEN-1:0] pend_q   [QDEPTH];

  logic [PW-1:0]       q_head_q, q_head_d, q_tail_q, q_tail_d;
  logic [PW-1:0]       p_head_q, p_head_d, p_tail_q, p_tail_d;
  logic [CW-1:0]       count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d;

  logic                redirect_c, credit_ok_c, accept_c, rsp_keep_c, pop_c;
  logic [WORD_LEN-1:0] off_sh_c, target_c;
  entry_t              head_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Redirect target and issue/output handshakes
  always_comb begin
    redirect_c  = jump_enable_i | br_taken_i;
    off_sh_c    = br_offset_i << OFFSET_SHIFT;
    target_c    = jump_enable_i ? off_sh_c : br_pc_i + off_sh_c;
    credit_ok_c = ({1'b0, count_q} + {1'b0, outst_q}) < (CW + 1)'(QDEPTH);
    imem_req_o  = !rst_i && !redirect_c && credit_ok_c;
    imem_addr_o = fetch_pc_q;
    accept_c    = imem_req_o && imem_gnt_i;
    rsp_keep_c  = imem_rsp_valid_i && (drop_q == '0) && !redirect_c;
    out_valid_o = !rst_i && (count_q != '0) && !redirect_c;
    pop_c       = out_valid_o && !freeze_i;
    head_c      = q_mem_q[q_head_q];
    pc_o          = (count_q != '0) ? head_c.pc    : '0;
    instruction_o = (count_q != '0) ? head_c.instr : '0;
  end

  // Next-state for pointers, counters and fetch PC
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    q_head_d   = q_head_q;
    q_tail_d   = q_tail_q;
    p_head_d   = p_head_q;
    p_tail_d   = p_tail_q;
    count_d    = count_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(accept_c) - CW'(imem_rsp_valid_i);

    if (accept_c) begin
      fetch_pc_d = fetch_pc_q + WORD_LEN'(ADDR_STEP);
      p_tail_d   = ptr_inc(p_tail_q);
    end
    if (imem_rsp_valid_i) p_head_d = ptr_inc(p_head_q);

    if (redirect_c) begin
      // Every request still in flight after this edge belongs to the old path.
      fetch_pc_d = target_c;
      q_head_d   = '0;
      q_tail_d   = '0;
      count_d    = '0;
      drop_d     = outst_q - CW'(imem_rsp_valid_i);
    end else begin
      if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (rsp_keep_c) q_tail_d = ptr_inc(q_tail_q);
      if (pop_c) q_head_d = ptr_inc(q_head_q);
      count_d = count_q + CW'(rsp_keep_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= WORD_LEN'(RESET_PC);
      q_head_q   <= '0;
      q_tail_q   <= '0;
      p_head_q   <= '0;
      p_tail_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      q_head_q   <= q_head_d;
      q_tail_q   <= q_tail_d;
      p_head_q   <= p_head_d;
      p_tail_q   <= p_tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters above
  always_ff @(posedge clk_i) begin
    if (accept_c) pend_q[p_tail_q] <= fetch_pc_q;
    if (rsp_keep_c) q_mem_q[q_tail_q] <= '{pc: pend_q[p_head_q], instr: imem_rsp_data_i};
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage: epoch-tagged memory model and an
// ordered expected-instruction queue derived from the fetch/redirect rules.
module tb_fetch_queue_stage;

  localparam int unsigned QD     = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, freeze, br_taken, jump_en, imem_gnt, rsp_v;
  logic [15:0] br_pc, br_off, rsp_data;
  logic        imem_req, out_valid;
  logic [15:0] imem_addr, pc, instr;

  fetch_queue_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .freeze_i        (freeze),
    .br_taken_i      (br_taken),
    .br_pc_i         (br_pc),
    .jump_enable_i   (jump_en),
    .br_offset_i     (br_off),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_gnt_i      (imem_gnt),
    .imem_rsp_valid_i(rsp_v),
    .imem_rsp_data_i (rsp_data),
    .out_valid_o     (out_valid),
    .pc_o            (pc),
    .instruction_o   (instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  mreq_t       mem[$];
  ent_t        mq[$];
  int          n_checks = 0, n_errors = 0;
  int          cyc = 0, lat = 1, epoch = 0;
  bit          rand_gnt = 0, rand_rsp = 0;
  logic [15:0] m_fetch = RST_PC, exp_next = RST_PC;
  logic        s_req, s_valid;
  logic [15:0] s_addr, s_pc, s_instr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  // One clock: drive inputs, sample outputs, compare and advance the model
  task automatic cycle(input bit r, input bit f, input bit b, input bit j,
                       input logic [15:0] bp, input logic [15:0] bo);
    logic [15:0] tgt;
    bit          redir, acc, exp_req, exp_valid;
    mreq_t       e;
    @(negedge clk);
    rst = r; freeze = f; br_taken = b; jump_en = j; br_pc = bp; br_off = bo;
    imem_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    rsp_v    = !r && mem.size() > 0 && mem[0].due <= cyc &&
               (!rand_rsp || $urandom_range(0, 3) != 0);
    rsp_data = rsp_v ? instr_of(mem[0].addr) : 16'($urandom);
    #1;
    s_req = imem_req; s_valid = out_valid; s_addr = imem_addr; s_pc = pc; s_instr = instr;
    redir = b | j;
    tgt   = j ? 16'(bo << 1) : 16'(bp + 16'(bo << 1));
    if (r) begin
      check_eq("rst_req", 32'(s_req), 0);
      check_eq("rst_valid", 32'(s_valid), 0);
      mq.delete(); mem.delete();
      m_fetch = RST_PC; exp_next = RST_PC; epoch++;
    end else begin
      exp_req   = !redir && (mq.size() + mem.size() < QD);
      exp_valid = !redir && mq.size() > 0;
      check_eq("req", 32'(s_req), 32'(exp_req));
      check_eq("valid", 32'(s_valid), 32'(exp_valid));
      if (s_req) check_eq("addr", 32'(s_addr), 32'(m_fetch));
      if (exp_valid && s_valid) begin
        check_eq("pc", 32'(s_pc), 32'(mq[0].pc));
        check_eq("instr", 32'(s_instr), 32'(mq[0].instr));
      end
      if (mq.size() == 0) check_eq("empty_pc", 32'(s_pc), 0);
      if (rsp_v) check_eq("rsp_into_full", 32'(mq.size() >= QD), 0);
      if (exp_valid && !f) begin
        check_eq("order", 32'(s_pc), 32'(exp_next));
        exp_next = mq[0].pc + 16'd4;
        void'(mq.pop_front());
      end
      acc = s_req && imem_gnt;
      if (rsp_v) begin
        e = mem.pop_front();
        if (e.epoch == epoch && !redir) mq.push_back('{pc: e.addr, instr: instr_of(e.addr)});
      end
      if (redir) begin
        mq.delete(); epoch++; m_fetch = tgt; exp_next = tgt;
      end else if (acc) begin
        mem.push_back('{addr: s_addr, epoch: epoch, due: cyc + lat});
        m_fetch = m_fetch + 16'd4;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) cycle(0, f, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic wait_valid(input string tag, input int limit, input logic [15:0] exp_pc,
                            input int exp_wait);
    int  k;
    bit  seen;
    seen = 0;
    for (k = 1; k <= limit; k++) begin
      idle(1, 0);
      if (s_valid) begin
        seen = 1;
        break;
      end
    end
    check_eq({tag, "_seen"}, 32'(seen), 1);
    if (seen) begin
      check_eq({tag, "_pc"}, 32'(s_pc), 32'(exp_pc));
      if (exp_wait > 0) check_eq({tag, "_latency"}, 32'(k), 32'(exp_wait));
    end
  endtask

  initial begin
    logic        ev [5];
    logic [15:0] ea [5];
    logic [15:0] ep [5];
    rst = 1; freeze = 0; br_taken = 0; jump_en = 0; br_pc = '0; br_off = '0;
    imem_gnt = 0; rsp_v = 0; rsp_data = '0;

    // Reset then sequential fetch with a 1-cycle memory
    cycle(1, 0, 0, 0, 16'h0, 16'h0);
    cycle(1, 0, 0, 0, 16'h0, 16'h0);
    ev = '{0, 0, 1, 1, 1};
    ea = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10};
    ep = '{16'h0, 16'h0, 16'h0, 16'h4, 16'h8};
    for (int k = 0; k < 5; k++) begin
      idle(1, 0);
      check_eq("seq_addr", 32'(s_addr), 32'(ea[k]));
      check_eq("seq_valid", 32'(s_valid), 32'(ev[k]));
      if (ev[k]) check_eq("seq_pc", 32'(s_pc), 32'(ep[k]));
    end

    // Queue fill under a long freeze, then release
    idle(10, 1);
    check_eq("fill_req", 32'(s_req), 0);
    check_eq("fill_hold_pc", 32'(s_pc), 32'h000C);
    idle(1, 0);
    check_eq("release_pc0", 32'(s_pc), 32'h000C);
    idle(1, 0);
    check_eq("release_pc1", 32'(s_pc), 32'h0010);
    idle(4, 0);

    // PC-relative branch
    cycle(0, 0, 1, 0, 16'h0010, 16'h0008);
    check_eq("br_req_n", 32'(s_req), 0);
    check_eq("br_valid_n", 32'(s_valid), 0);
    idle(1, 0);
    check_eq("br_req_n1", 32'(s_req), 1);
    check_eq("br_addr_n1", 32'(s_addr), 32'h0020);
    wait_valid("br", 10, 16'h0020, 2);
    idle(4, 0);

    // Jump with two requests outstanding under a 3-cycle memory
    cycle(1, 0, 0, 0, 16'h0, 16'h0);
    lat = 3;
    idle(2, 0);
    cycle(0, 0, 0, 1, 16'h0, 16'h0040);
    wait_valid("jmp", 12, 16'h0080, 5);
    idle(6, 0);

    // Jump and branch together with a response in the same cycle
    cycle(0, 0, 1, 1, 16'h0100, 16'h0030);
    wait_valid("both", 12, 16'h0060, 0);
    idle(8, 0);

    // Reset mid-stream with a full queue and freeze held
    idle(10, 1);
    cycle(1, 1, 0, 0, 16'h0, 16'h0);
    idle(1, 1);
    check_eq("rst_mid_valid", 32'(s_valid), 0);
    check_eq("rst_mid_req", 32'(s_req), 1);
    check_eq("rst_mid_addr", 32'(s_addr), 32'(RST_PC));
    idle(6, 0);

    // Random traffic: stalls, grant gaps, variable latency, redirects, resets
    rand_gnt = 1; rand_rsp = 1;
    for (int i = 0; i < 3000; i++) begin
      bit r, f, b, j;
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 24) == 0);
      j = ($urandom_range(0, 39) == 0);
      cycle(r, f, b, j, 16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
